// File: rtl/game_timer_pkg.sv
// Shared types and constants for the game_timer HUD stopwatch.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    MAXED   = 2'd3
  } game_timer_state_t;

  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [11:0] TIME_MAX = {4'd9, 4'd9, 4'd9};

endpackage

// File: rtl/game_timer_bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit (0..9) with synchronous clear and a
// combinational carry that is high on the increment that wraps 9 -> 0.
module bcd_digit_counter
  import game_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] r_digit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (en) begin
      // >= keeps the digit inside 0..9 even if an illegal code ever appears
      r_digit <= (r_digit >= BCD_MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign carry = en && (r_digit == BCD_MAX);
  assign digit = r_digit;

endmodule

// File: rtl/game_timer.sv
// game_timer: BCD play-time stopwatch (0.1 s resolution, saturates at 99.9 s)
// with a one-cycle second pulse. Define GAME_TIMER_FRAME_LATCH_EN to latch the
// displayed digits on frame_tick instead of showing the live count.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_reset,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  output logic [3:0] tenths,
  output logic [3:0] secs,
  output logic [3:0] secs_10s,
  output logic       second_tick,
  output logic       running,
  output logic       maxed
);

  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  game_timer_state_t r_state;
  game_timer_state_t w_next_state;

  logic [PW-1:0] r_presc;
  logic          r_second_tick;
  logic          w_count_en;
  logic          w_tick;
  logic          w_at_max;
  logic          w_digit_en;
  logic          w_tenths_carry;
  logic          w_secs_carry;
  logic          w_s10_carry;
  logic [3:0]    w_tenths;
  logic [3:0]    w_secs;
  logic [3:0]    w_s10;

  assign w_count_en = (r_state == RUNNING) && !pause;
  assign w_tick     = w_count_en && (r_presc == PRESC_LAST);
  assign w_at_max   = ({w_s10, w_secs, w_tenths} == TIME_MAX);
  // The saturating tick must not touch the digits; the FSM takes it instead.
  assign w_digit_en = w_tick && !w_at_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (game_reset) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_next_state = pause ? PAUSED : RUNNING;
          end
        end
        RUNNING: begin
          if (pause) begin
            w_next_state = PAUSED;
          end else if (w_tick && w_at_max) begin
            w_next_state = MAXED;
          end
        end
        PAUSED: begin
          if (!pause) begin
            w_next_state = RUNNING;
          end
        end
        MAXED: begin
          w_next_state = MAXED;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end
  end

  // Prescaler holds while not counting so a resume finishes the partial tenth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (game_reset) begin
      r_presc <= '0;
    end else if (w_count_en) begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + PW'(1);
    end
  end

  bcd_digit_counter u_tenths (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (game_reset),
    .en      (w_digit_en),
    .digit   (w_tenths),
    .carry   (w_tenths_carry)
  );

  bcd_digit_counter u_secs (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (game_reset),
    .en      (w_tenths_carry),
    .digit   (w_secs),
    .carry   (w_secs_carry)
  );

  bcd_digit_counter u_secs_10s (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (game_reset),
    .en      (w_secs_carry),
    .digit   (w_s10),
    .carry   (w_s10_carry)
  );

  // Registered alongside the secs update so the pulse lines up with the new value;
  // a full-scale roll out of the tens digit is never reported as a second.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_second_tick <= 1'b0;
    end else if (game_reset) begin
      r_second_tick <= 1'b0;
    end else begin
      r_second_tick <= w_tenths_carry && !w_s10_carry;
    end
  end

`ifdef GAME_TIMER_FRAME_LATCH_EN
  logic [3:0] r_disp_tenths;
  logic [3:0] r_disp_secs;
  logic [3:0] r_disp_s10;

  // Loads the pre-edge live value, so a coincident tick is shown next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_tenths <= '0;
      r_disp_secs   <= '0;
      r_disp_s10    <= '0;
    end else if (game_reset) begin
      r_disp_tenths <= '0;
      r_disp_secs   <= '0;
      r_disp_s10    <= '0;
    end else if (frame_tick) begin
      r_disp_tenths <= w_tenths;
      r_disp_secs   <= w_secs;
      r_disp_s10    <= w_s10;
    end
  end

  assign tenths   = r_disp_tenths;
  assign secs     = r_disp_secs;
  assign secs_10s = r_disp_s10;
`else
  logic w_unused_frame_tick;
  assign w_unused_frame_tick = frame_tick;

  assign tenths   = w_tenths;
  assign secs     = w_secs;
  assign secs_10s = w_s10;
`endif

  assign second_tick = r_second_tick;
  assign running     = (r_state == RUNNING);
  assign maxed       = (r_state == MAXED);

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer with TICK_DIV = 4; expectations are queued
// when stimulus is applied and popped when the DUT result is sampled.
module tb_game_timer;
  import game_timer_pkg::*;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       game_reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       frame_tick = 1'b0;
  logic [3:0] tenths;
  logic [3:0] secs;
  logic [3:0] secs_10s;
  logic       second_tick;
  logic       running;
  logic       maxed;

  typedef struct packed {
    logic [3:0] s10;
    logic [3:0] s;
    logic [3:0] t;
    logic       run;
    logic       mx;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  game_timer #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .game_reset  (game_reset),
    .start       (start),
    .pause       (pause),
    .frame_tick  (frame_tick),
    .tenths      (tenths),
    .secs        (secs),
    .secs_10s    (secs_10s),
    .second_tick (second_tick),
    .running     (running),
    .maxed       (maxed)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int s10, input int s, input int t, input bit run, input bit mx);
    obs_t v;
    v.s10 = 4'(s10);
    v.s   = 4'(s);
    v.t   = 4'(t);
    v.run = run;
    v.mx  = mx;
    return v;
  endfunction

  function automatic obs_t sample();
    return mk(int'(secs_10s), int'(secs), int'(tenths), running, maxed);
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("%0d%0d.%0d run=%0b max=%0b", v.s10, v.s, v.t, v.run, v.mx);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_game();
    game_reset = 1'b1;
    step();
    game_reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, got;
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    step(2);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e || second_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %s stick=%0b, expected %s stick=0", fmt(got), second_tick, fmt(e));
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic_count();
    obs_t e, got;
    int pulses = 0;
    clear_game();
    exp_q.push_back(mk(0, 1, 0, 1'b1, 1'b0));
    do_start();
    n_chk++;
    if (running !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: running=%0b, expected 1", running);
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 3) begin
        n_chk++;
        if (tenths !== 4'd0) begin
          n_fail++;
          $display("FAIL first_tick_early: tenths=%0d, expected 0", tenths);
        end
      end
      if (c == 4) begin
        n_chk++;
        if (tenths !== 4'd1) begin
          n_fail++;
          $display("FAIL first_tick: tenths=%0d, expected 1", tenths);
        end
      end
      if (second_tick === 1'b1) begin
        pulses++;
        n_chk++;
        if (secs !== 4'd1 || tenths !== 4'd0 || c != 40) begin
          n_fail++;
          $display("FAIL stick_coincident: cycle %0d secs=%0d tenths=%0d, expected cycle 40 secs=1 tenths=0", c, secs, tenths);
        end
      end
    end
    n_chk++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL stick_count: got %0d pulses, expected 1", pulses);
    end
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL basic_1s: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_pause();
    obs_t e, got;
    clear_game();
    do_start();
    step(2);
    pause = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    step(20);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_frozen: got %s, expected %s", fmt(got), fmt(e));
    end
    pause = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 1, 1'b1, 1'b0));
    step(2);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_resume_early: got %s, expected %s", fmt(got), fmt(e));
    end
    step();
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_resume_tick: got %s, expected %s", fmt(got), fmt(e));
    end
    // prescaler now at TD-1 with the tick due on the next edge; pause suppresses it
    step(3);
    pause = 1'b1;
    exp_q.push_back(mk(0, 0, 1, 1'b0, 1'b0));
    step(5);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_tick_suppressed: got %s, expected %s", fmt(got), fmt(e));
    end
    pause = 1'b0;
    exp_q.push_back(mk(0, 0, 2, 1'b1, 1'b0));
    step(2);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pause_held_prescaler: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_priority();
    obs_t e, got;
    clear_game();
    do_start();
    exp_q.push_back(mk(1, 2, 3, 1'b1, 1'b0));
    step(123 * TD);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL run_to_12_3: got %s, expected %s", fmt(got), fmt(e));
    end
    game_reset = 1'b1;
    start = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    step();
    game_reset = 1'b0;
    start = 1'b0;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_beats_start: got %s, expected %s", fmt(got), fmt(e));
    end
    step(8);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_start_paused();
    obs_t e, got;
    clear_game();
    pause = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    do_start();
    step(10);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL start_paused: got %s, expected %s", fmt(got), fmt(e));
    end
    pause = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 1, 1'b1, 1'b0));
    step();
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL paused_to_running: got %s, expected %s", fmt(got), fmt(e));
    end
    step(TD);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL paused_first_tick: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_frame_latch();
    obs_t e, got;
    clear_game();
    do_start();
`ifdef GAME_TIMER_FRAME_LATCH_EN
    exp_q.push_back(mk(0, 0, 0, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 5, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 5, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 6, 1'b1, 1'b0));
    step(20);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL latch_hold: got %s, expected %s", fmt(got), fmt(e));
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL latch_load: got %s, expected %s", fmt(got), fmt(e));
    end
    step(2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL latch_pre_increment: got %s, expected %s", fmt(got), fmt(e));
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL latch_next_frame: got %s, expected %s", fmt(got), fmt(e));
    end
`else
    exp_q.push_back(mk(0, 0, 1, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 5, 1'b1, 1'b0));
    exp_q.push_back(mk(0, 0, 5, 1'b1, 1'b0));
    step(TD);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL live_follow_0_1: got %s, expected %s", fmt(got), fmt(e));
    end
    step(20 - TD);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL live_follow_0_5: got %s, expected %s", fmt(got), fmt(e));
    end
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL frame_tick_ignored: got %s, expected %s", fmt(got), fmt(e));
    end
`endif
  endtask

  task automatic test_async_reset();
    obs_t e, got;
    clear_game();
    do_start();
    step(2 * TD + 1);
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL async_reset: got %s, expected %s", fmt(got), fmt(e));
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_saturation();
    obs_t e, got;
    int pulses = 0;
    clear_game();
    do_start();
    exp_q.push_back(mk(9, 9, 9, 1'b1, 1'b0));
    for (int c = 0; c < 999 * TD; c++) begin
      step();
      if (second_tick === 1'b1) pulses++;
    end
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reach_99_9: got %s, expected %s", fmt(got), fmt(e));
    end
    n_chk++;
    if (pulses != 99) begin
      n_fail++;
      $display("FAIL stick_total: got %0d pulses, expected 99", pulses);
    end
    pulses = 0;
    exp_q.push_back(mk(9, 9, 9, 1'b0, 1'b1));
    for (int c = 0; c < TD + 1; c++) begin
      step();
      if (second_tick === 1'b1) pulses++;
    end
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e || pulses != 0) begin
      n_fail++;
      $display("FAIL saturate: got %s pulses=%0d, expected %s pulses=0", fmt(got), pulses, fmt(e));
    end
    exp_q.push_back(mk(9, 9, 9, 1'b0, 1'b1));
    do_start();
    step(8);
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL maxed_sticky: got %s, expected %s", fmt(got), fmt(e));
    end
    exp_q.push_back(mk(0, 0, 0, 1'b0, 1'b0));
    clear_game();
    e = exp_q.pop_front();
    got = sample();
    n_chk++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL maxed_exit: got %s, expected %s", fmt(got), fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_pause();
    test_priority();
    test_start_paused();
    test_frame_latch();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
